fft8_sched: RTL and testbench

- Sequencing controller for one shared radix-2 butterfly datapath computing an 8-point complex FFT (FP32, decimation in time).
- Accepts 8 input samples over a valid/ready stream and stores them bit-reversed in an internal 8-entry complex buffer.
- Drives the external combinational butterfly for 3 stages × 4 butterflies, writing results back in place.
- Streams the 8 results out in natural order over a valid/ready stream.

---
 rtl/fft8_sched.sv | 212 +++++++++++++++++++++
 tb/tb_fft8_sched.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft8_sched.sv
// fft8_sched: load / compute / unload sequencer for an 8-point radix-2 DIT FFT
// built around a single external combinational butterfly.
module fft8_sched #(
    parameter int DW = 32,
    parameter int N  = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic [DW-1:0] i_in_re,
    input  logic [DW-1:0] i_in_im,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [DW-1:0] o_out_re,
    output logic [DW-1:0] o_out_im,
    output logic          o_out_last,
    output logic [DW-1:0] o_bf_data_0_re,
    output logic [DW-1:0] o_bf_data_0_im,
    output logic [DW-1:0] o_bf_data_1_re,
    output logic [DW-1:0] o_bf_data_1_im,
    output logic [DW-1:0] o_bf_twiddle_re,
    output logic [DW-1:0] o_bf_twiddle_im,
    input  logic [DW-1:0] i_bf_data_0_re,
    input  logic [DW-1:0] i_bf_data_0_im,
    input  logic [DW-1:0] i_bf_data_1_re,
    input  logic [DW-1:0] i_bf_data_1_im,
    output logic          o_busy,
    output logic          o_done
);

    generate
        if (N != 8) begin : g_badSize
            $error("fft8_sched supports only N = 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMPUTE,
        UNLOAD
    } state_t;

    localparam logic [DW-1:0] W_ZERO    = DW'(32'h00000000);
    localparam logic [DW-1:0] W_ONE     = DW'(32'h3F800000);
    localparam logic [DW-1:0] W_NEG_ONE = DW'(32'hBF800000);
    localparam logic [DW-1:0] W_RT_HALF = DW'(32'h3F3504F3);
    localparam logic [DW-1:0] W_NEG_RT  = DW'(32'hBF3504F3);

    state_t        r_state;
    logic [2:0]    r_inCount;
    logic [3:0]    r_bfCount;
    logic [2:0]    r_outIdx;
    logic          r_inReady;
    logic          r_outValid;
    logic          r_busy;
    logic          r_done;
    logic [DW-1:0] r_bufRe [N];
    logic [DW-1:0] r_bufIm [N];

    logic          w_inFire;
    logic          w_outFire;
    logic          w_computing;
    logic [2:0]    w_inAddr;
    logic [1:0]    w_stage;
    logic [1:0]    w_j;
    logic [2:0]    w_top;
    logic [2:0]    w_bot;
    logic [1:0]    w_twIdx;
    logic [DW-1:0] w_twRe;
    logic [DW-1:0] w_twIm;

    assign w_inFire    = i_in_valid && r_inReady;
    assign w_outFire   = r_outValid && i_out_ready;
    assign w_computing = (r_state == COMPUTE);
    assign w_inAddr    = {r_inCount[0], r_inCount[1], r_inCount[2]};
    assign w_stage     = r_bfCount[3:2];
    assign w_j         = r_bfCount[1:0];

    // Operand pair of butterfly j in stage s; the span doubles every stage.
    always_comb begin
        w_top   = 3'd0;
        w_bot   = 3'd0;
        w_twIdx = 2'd0;
        case (w_stage)
            2'd0: begin
                w_top   = {w_j, 1'b0};
                w_bot   = {w_j, 1'b1};
                w_twIdx = 2'd0;
            end
            2'd1: begin
                w_top   = {w_j[1], 1'b0, w_j[0]};
                w_bot   = {w_j[1], 1'b1, w_j[0]};
                w_twIdx = {w_j[0], 1'b0};
            end
            default: begin
                w_top   = {1'b0, w_j};
                w_bot   = {1'b1, w_j};
                w_twIdx = w_j;
            end
        endcase
    end

    always_comb begin
        w_twRe = W_ONE;
        w_twIm = W_ZERO;
        case (w_twIdx)
            2'd0: begin
                w_twRe = W_ONE;
                w_twIm = W_ZERO;
            end
            2'd1: begin
                w_twRe = W_RT_HALF;
                w_twIm = W_NEG_RT;
            end
            2'd2: begin
                w_twRe = W_ZERO;
                w_twIm = W_NEG_ONE;
            end
            default: begin
                w_twRe = W_NEG_RT;
                w_twIm = W_NEG_RT;
            end
        endcase
    end

    assign o_bf_data_0_re  = w_computing ? r_bufRe[w_top] : '0;
    assign o_bf_data_0_im  = w_computing ? r_bufIm[w_top] : '0;
    assign o_bf_data_1_re  = w_computing ? r_bufRe[w_bot] : '0;
    assign o_bf_data_1_im  = w_computing ? r_bufIm[w_bot] : '0;
    assign o_bf_twiddle_re = w_computing ? w_twRe : '0;
    assign o_bf_twiddle_im = w_computing ? w_twIm : '0;

    assign o_in_ready  = r_inReady;
    assign o_out_valid = r_outValid;
    assign o_out_re    = r_outValid ? r_bufRe[r_outIdx] : '0;
    assign o_out_im    = r_outValid ? r_bufIm[r_outIdx] : '0;
    assign o_out_last  = r_outValid && (r_outIdx == 3'd7);
    assign o_busy      = r_busy;
    assign o_done      = r_done;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_inCount  <= 3'd0;
            r_bfCount  <= 4'd0;
            r_outIdx   <= 3'd0;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, LOAD: begin
                    if (w_inFire) begin
                        r_inCount <= r_inCount + 3'd1;
                        r_busy    <= 1'b1;
                        if (r_inCount == 3'd7) begin
                            r_state   <= COMPUTE;
                            r_inReady <= 1'b0;
                            r_bfCount <= 4'd0;
                        end else begin
                            r_state <= LOAD;
                        end
                    end
                end
                COMPUTE: begin
                    if (r_bfCount == 4'd11) begin
                        r_bfCount  <= 4'd0;
                        r_state    <= UNLOAD;
                        r_outValid <= 1'b1;
                        r_outIdx   <= 3'd0;
                    end else begin
                        r_bfCount <= r_bfCount + 4'd1;
                    end
                end
                UNLOAD: begin
                    if (w_outFire) begin
                        r_outIdx <= r_outIdx + 3'd1;
                        if (r_outIdx == 3'd7) begin
                            r_state    <= IDLE;
                            r_outValid <= 1'b0;
                            r_inReady  <= 1'b1;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_inCount  <= 3'd0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Samples land bit-reversed so the in-place DIT passes finish in natural order.
    always_ff @(posedge i_clk) begin
        if (w_inFire) begin
            r_bufRe[w_inAddr] <= i_in_re;
            r_bufIm[w_inAddr] <= i_in_im;
        end else if (w_computing) begin
            r_bufRe[w_top] <= i_bf_data_0_re;
            r_bufIm[w_top] <= i_bf_data_0_im;
            r_bufRe[w_bot] <= i_bf_data_1_re;
            r_bufIm[w_bot] <= i_bf_data_1_im;
        end
    end

endmodule

// File: tb/tb_fft8_sched.sv
// Scoreboard bench for fft8_sched: a behavioural butterfly feeds the DUT and a
// direct DFT model predicts every output bin.
module tb_fft8_sched;

    localparam int DW = 32;
    localparam logic [31:0] F_ONE = 32'h3F800000;

    logic          clk = 1'b0;
    logic          rst;
    logic          inValid;
    logic          inReady;
    logic [DW-1:0] inRe;
    logic [DW-1:0] inIm;
    logic          outValid;
    logic          outReady;
    logic [DW-1:0] outRe;
    logic [DW-1:0] outIm;
    logic          outLast;
    logic [DW-1:0] bfA0Re, bfA0Im, bfA1Re, bfA1Im, twRe, twIm;
    logic [DW-1:0] bfY0Re, bfY0Im, bfY1Re, bfY1Im;
    logic          busy;
    logic          done;

    int  vectors = 0;
    int  miscompares = 0;
    int  cyc = 0;
    int  computeIdx = 0;
    int  doneCount = 0;
    int  framesExpected = 0;
    int  lastBeatCyc = 0;
    bit  latencyPending = 1'b0;
    bit  doneExpected = 1'b0;
    bit  stallArmed = 1'b0;
    bit  randomReady = 1'b0;
    int  stallLeft = 0;
    real expReQ[$];
    real expImQ[$];
    int  expBinQ[$];

    fft8_sched #(.DW(DW), .N(8)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_in_valid     (inValid),
        .o_in_ready     (inReady),
        .i_in_re        (inRe),
        .i_in_im        (inIm),
        .o_out_valid    (outValid),
        .i_out_ready    (outReady),
        .o_out_re       (outRe),
        .o_out_im       (outIm),
        .o_out_last     (outLast),
        .o_bf_data_0_re (bfA0Re),
        .o_bf_data_0_im (bfA0Im),
        .o_bf_data_1_re (bfA1Re),
        .o_bf_data_1_im (bfA1Im),
        .o_bf_twiddle_re(twRe),
        .o_bf_twiddle_im(twIm),
        .i_bf_data_0_re (bfY0Re),
        .i_bf_data_0_im (bfY0Im),
        .i_bf_data_1_re (bfY1Re),
        .i_bf_data_1_im (bfY1Im),
        .o_busy         (busy),
        .o_done         (done)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Single-precision <-> real conversion; denormals flush to zero.
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        logic [10:0] e;
        if (f[30:23] == 8'd0) return 0.0;
        e = {3'b000, f[30:23]} + 11'd896;
        d = {f[31], e, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int e;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        if (e <= 0) return {d[63], 31'd0};
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        return {d[63], e[7:0], d[51:29]};
    endfunction

    real bAr, bAi, bBr, bBi, bWr, bWi, bTr, bTi;
    always_comb begin
        bAr = f2r(bfA0Re);
        bAi = f2r(bfA0Im);
        bBr = f2r(bfA1Re);
        bBi = f2r(bfA1Im);
        bWr = f2r(twRe);
        bWi = f2r(twIm);
        bTr = bWr * bBr - bWi * bBi;
        bTi = bWr * bBi + bWi * bBr;
        bfY0Re = r2f(bAr + bTr);
        bfY0Im = r2f(bAi + bTi);
        bfY1Re = r2f(bAr - bTr);
        bfY1Im = r2f(bAi - bTi);
    end

    function automatic real rndUnit();
        return real'($urandom_range(0, 2000)) / 1000.0 - 1.0;
    endfunction

    // Twiddle order: stage 0 all W^0, stage 1 W^0,W^2,W^0,W^2, stage 2 W^0..W^3.
    function automatic logic [63:0] twExpect(input int idx);
        int k;
        if (idx < 4) k = 0;
        else if (idx < 8) k = (idx % 2) * 2;
        else k = idx - 8;
        case (k)
            0:       return {32'h3F800000, 32'h00000000};
            1:       return {32'h3F3504F3, 32'hBF3504F3};
            2:       return {32'h00000000, 32'hBF800000};
            default: return {32'hBF3504F3, 32'hBF3504F3};
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkNear(input string name, input real act, input real exp);
        vectors = vectors + 1;
        if ((act - exp > 1.0e-3) || (exp - act > 1.0e-3)) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s: got %f, expected %f", name, act, exp);
        end
    endtask

    // Builds a frame, pushes its DFT into the scoreboard, then streams it in.
    task automatic applyStimulus(input int mode, input bit gapped);
        logic [31:0] fr [8];
        logic [31:0] fi [8];
        real xr [8];
        real xi [8];
        real sr, si, th;
        int n, guard;
        for (int i = 0; i < 8; i++) begin
            fr[i] = 32'h0;
            fi[i] = 32'h0;
        end
        case (mode)
            0: fr[0] = F_ONE;
            1: for (int i = 0; i < 8; i++) fr[i] = F_ONE;
            2: fr[1] = F_ONE;
            default: begin
                for (int i = 0; i < 8; i++) begin
                    fr[i] = r2f(rndUnit());
                    fi[i] = r2f(rndUnit());
                end
            end
        endcase
        for (int i = 0; i < 8; i++) begin
            xr[i] = f2r(fr[i]);
            xi[i] = f2r(fi[i]);
        end
        for (int k = 0; k < 8; k++) begin
            sr = 0.0;
            si = 0.0;
            for (int m = 0; m < 8; m++) begin
                th = 2.0 * 3.14159265358979 * real'(k * m) / 8.0;
                sr = sr + xr[m] * $cos(th) + xi[m] * $sin(th);
                si = si + xi[m] * $cos(th) - xr[m] * $sin(th);
            end
            expReQ.push_back(sr);
            expImQ.push_back(si);
            expBinQ.push_back(k);
        end
        n = 0;
        guard = 0;
        while (n < 8 && guard < 400) begin
            if (gapped && (guard % 2 == 1)) begin
                inValid = 1'b0;
            end else begin
                inValid = 1'b1;
                inRe = fr[n];
                inIm = fi[n];
                if (inReady) begin
                    if (n == 7) begin
                        lastBeatCyc = cyc;
                        latencyPending = 1'b1;
                    end
                    n = n + 1;
                end
            end
            @(negedge clk);
            guard = guard + 1;
        end
        inValid = 1'b0;
        if (n < 8) begin
            vectors = vectors + 1;
            miscompares = miscompares + 1;
            $display("[TB] FAIL load_timeout: got %0d beats, expected 8", n);
        end
    endtask

    task automatic waitFrameDone();
        int t;
        t = 0;
        while (!done && t < 300) begin
            @(negedge clk);
            t = t + 1;
        end
        if (!done) begin
            vectors = vectors + 1;
            miscompares = miscompares + 1;
            $display("[TB] FAIL done_timeout: got no o_done, expected one within 300 cycles");
        end
        @(negedge clk);
        framesExpected = framesExpected + 1;
    endtask

    // Monitor: twiddle sequence, done pulse, latency and scoreboard pops.
    initial begin
        outReady = 1'b1;
        forever begin
            @(negedge clk);
            if (busy && !inReady && !outValid && !rst) begin
                if (computeIdx < 12)
                    checkOutput($sformatf("twiddle%0d", computeIdx), {twRe, twIm}, twExpect(computeIdx));
                else
                    checkOutput("compute_len", 64'(computeIdx), 64'd11);
                computeIdx = computeIdx + 1;
            end else begin
                computeIdx = 0;
            end
            if (done || doneExpected)
                checkOutput("done_pulse", 64'(done), 64'(doneExpected));
            if (done) doneCount = doneCount + 1;
            doneExpected = 1'b0;
            if (outValid) begin
                if (latencyPending) begin
                    checkOutput("latency", 64'(cyc - lastBeatCyc), 64'd13);
                    latencyPending = 1'b0;
                end
                if (expBinQ.size() == 0) begin
                    vectors = vectors + 1;
                    miscompares = miscompares + 1;
                    $display("[TB] FAIL extra_bin: got output %h, expected none", outRe);
                    outReady = 1'b1;
                end else begin
                    checkNear($sformatf("bin%0d_re", expBinQ[0]), f2r(outRe), expReQ[0]);
                    checkNear($sformatf("bin%0d_im", expBinQ[0]), f2r(outIm), expImQ[0]);
                    checkOutput($sformatf("bin%0d_last", expBinQ[0]), 64'(outLast), 64'(expBinQ[0] == 7));
                    if (stallArmed && expBinQ[0] == 4) begin
                        stallArmed = 1'b0;
                        stallLeft = 3;
                    end
                    if (stallLeft > 0) begin
                        outReady = 1'b0;
                        stallLeft = stallLeft - 1;
                    end else if (randomReady && $urandom_range(0, 2) == 0) begin
                        outReady = 1'b0;
                    end else begin
                        outReady = 1'b1;
                        if (expBinQ[0] == 7) doneExpected = 1'b1;
                        void'(expReQ.pop_front());
                        void'(expImQ.pop_front());
                        void'(expBinQ.pop_front());
                    end
                end
            end else begin
                outReady = 1'b1;
            end
        end
    end

    initial begin
        #300000;
        miscompares = miscompares + 1;
        $display("[TB] FAIL watchdog: got no finish, expected end within 300000 time units");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        int t;
        rst = 1'b1;
        inValid = 1'b0;
        inRe = '0;
        inIm = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", 64'(inReady), 64'd1);
        checkOutput("rst_out_valid", 64'(outValid), 64'd0);
        checkOutput("rst_out_last", 64'(outLast), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_bf_data", {bfA0Re, bfA1Im}, 64'd0);
        checkOutput("rst_twiddle", {twRe, twIm}, 64'd0);
        checkOutput("rst_out_data", {outRe, outIm}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] impulse frame");
        applyStimulus(0, 1'b0);
        waitFrameDone();
        $display("[TB] DC frame");
        applyStimulus(1, 1'b0);
        waitFrameDone();
        $display("[TB] x[1] frame");
        applyStimulus(2, 1'b0);
        waitFrameDone();

        $display("[TB] gapped input with output stall at bin 4");
        stallArmed = 1'b1;
        applyStimulus(3, 1'b1);
        waitFrameDone();

        $display("[TB] reset during compute");
        applyStimulus(1, 1'b0);
        t = 0;
        while (computeIdx < 6 && t < 100) begin
            @(negedge clk);
            t = t + 1;
        end
        checkOutput("reach_compute6", 64'(computeIdx >= 6), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_in_ready", 64'(inReady), 64'd1);
        checkOutput("midrst_out_valid", 64'(outValid), 64'd0);
        expReQ.delete();
        expImQ.delete();
        expBinQ.delete();
        latencyPending = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(1, 1'b0);
        waitFrameDone();

        $display("[TB] back-to-back frames");
        applyStimulus(3, 1'b0);
        waitFrameDone();
        checkOutput("b2b_in_ready", 64'(inReady), 64'd1);
        applyStimulus(3, 1'b0);
        waitFrameDone();

        $display("[TB] random frames with random backpressure");
        randomReady = 1'b1;
        for (int f = 0; f < 4; f++) begin
            applyStimulus(3, f[0]);
            waitFrameDone();
        end
        randomReady = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("queue_empty", 64'(expBinQ.size()), 64'd0);
        checkOutput("done_count", 64'(doneCount), 64'(framesExpected));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
